dmem_store_buffer: RTL

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

---
 rtl/dmem_store_buffer_pkg.sv | 28 ++
 rtl/dmem_store_buffer_array.sv | 35 +++
 rtl/dmem_store_buffer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// Shared defines for the data-memory store buffer.
//   XLEN      : machine word width in bits
//   ADDR_SIZE : byte-address width
//   SB_DEPTH  : default number of store-buffer entries
//   mergeBytes: per-lane select between a base word and an override word
package dmem_store_buffer_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 32;
    localparam int SB_DEPTH  = 4;

    // Lane i of the result is over[i] when mask[i] is set, otherwise base[i].
    function automatic logic [XLEN-1:0] mergeBytes(
        input logic [XLEN-1:0]   base,
        input logic [XLEN-1:0]   over,
        input logic [XLEN/8-1:0] mask
    );
        logic [XLEN-1:0] res;
        res = base;
        for (int b = 0; b < XLEN/8; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = over[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_store_buffer_array.sv
// Data array behind the store buffer: 2^AW words of 32 bits.
//   clk       : clock, writes on the rising edge
//   writeEn   : write strobe
//   writeMask : per-byte lane enables (bit i = byte i)
//   writeAddr : word index to write
//   writeData : lane-aligned write data
//   readAddr  : word index to read
//   readData  : asynchronous read data (a same-cycle write is not visible)
module dmem_array
    import dmem_store_buffer_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          writeEn,
    input  logic [3:0]    writeMask,
    input  logic [AW-1:0] writeAddr,
    input  logic [31:0]   writeData,
    input  logic [AW-1:0] readAddr,
    output logic [31:0]   readData
);

    logic [XLEN-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int b = 0; b < XLEN/8; b++) begin
            if (writeEn && writeMask[b]) begin
                mem[writeAddr][8*b +: 8] <= writeData[8*b +: 8];
            end
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/dmem_store_buffer.sv
// FIFO store buffer in front of the data array.
// Stores are queued and retired one per cycle whenever the write side is free
// (no load, and either no store or a full buffer). Loads see a byte-merged view:
// each lane comes from the youngest buffered store covering it, else the array.
//   clk       : clock
//   reset     : asynchronous, active-low
//   addrM     : byte address; word index is addrM[AW+1:2]
//   wdataM    : lane-aligned store data
//   memwriteM : store request
//   memreadM  : load request (never together with memwriteM)
//   ampM      : store byte-lane enables
//   readdataM : combinational forwarded load data
//   stallM    : combinational, store refused this cycle
//   sbemptyW  : registered, buffer holds no valid entries
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        memwriteM,
    input  logic        memreadM,
    input  logic [3:0]  ampM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        sbemptyW
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] validQ;
    logic [AW-1:0]    idxQ  [DEPTH];
    logic [31:0]      dataQ [DEPTH];
    logic [3:0]       maskQ [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;

    logic [AW-1:0] wordIdx;
    logic          full;
    logic          accept;
    logic          drain;

    logic [31:0]   arrayData;
    logic [31:0]   fwdData;
    logic [3:0]    fwdMask;

    // Address bits outside the word index carry no information here.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{addrM[31:AW+2], addrM[1:0]};

    assign wordIdx = addrM[AW+1:2];
    assign full    = (count == CW'(DEPTH));
    assign stallM  = memwriteM && full;
    assign accept  = memwriteM && !full;
    // A full buffer retires its head even under a store so the held store
    // gets in on the following cycle.
    assign drain   = (count != '0) && !memreadM && (!memwriteM || full);

    always_comb begin
        countNext = count;
        case ({accept, drain})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            sbemptyW <= 1'b1;
        end else begin
            if (drain) begin
                validQ[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            if (accept) begin
                validQ[tail] <= 1'b1;
                tail         <= tail + 1'b1;
            end
            count    <= countNext;
            sbemptyW <= (countNext == '0);
        end
    end

    // Entry payload needs no reset: validQ decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            idxQ[tail]  <= wordIdx;
            dataQ[tail] <= wdataM;
            maskQ[tail] <= ampM;
        end
    end

    dmem_array #(
        .AW(AW)
    ) uArray (
        .clk       (clk),
        .writeEn   (drain),
        .writeMask (maskQ[head]),
        .writeAddr (idxQ[head]),
        .writeData (dataQ[head]),
        .readAddr  (wordIdx),
        .readData  (arrayData)
    );

    // Walk from youngest (tail-1) to oldest; the first hit per lane wins.
    // Invalid slots are skipped, so only live entries take part.
    always_comb begin
        logic [PW-1:0] slot;
        fwdData = '0;
        fwdMask = '0;
        slot    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = tail - PW'(k + 1);
            if (validQ[slot] && (idxQ[slot] == wordIdx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (maskQ[slot][b] && !fwdMask[b]) begin
                        fwdMask[b]          = 1'b1;
                        fwdData[8*b +: 8]   = dataQ[slot][8*b +: 8];
                    end
                end
            end
        end
    end

    assign readdataM = mergeBytes(arrayData, fwdData, fwdMask);

endmodule
